// File: rtl/led_pulse_stretcher.sv
// led_pulse_stretcher: stretches single-cycle event strobes into visible LED flashes with a forced dark gap
module led_pulse_stretcher #(
  parameter int WIDTH       = 5,
  parameter int CNT_W       = 24,
  parameter int HOLD_CYCLES = 10_000_000,
  parameter int GAP_CYCLES  = 5_000_000,
  parameter int RETRIGGER   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pulse_in,
  output logic [WIDTH-1:0] led_out,
  output logic             busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ON   = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);
  localparam bit RETRIG = RETRIGGER != 0;
  logic [WIDTH-1:0] active_nxt;
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [1:0]       st, st_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             pend, pend_nxt;
    logic             led_q;
    logic             p;
    assign p = pulse_in[i];
    // Next-state logic: counters only load or count down, never below zero
    always_comb begin
      st_nxt   = st;
      cnt_nxt  = cnt;
      pend_nxt = pend;
      case (st)
        IDLE: begin
          if (p) begin
            st_nxt  = ON;
            cnt_nxt = HOLD_LD;
          end
        end
        ON: begin
          if (p && RETRIG) begin
            cnt_nxt = HOLD_LD;
          end else begin
            pend_nxt = pend | p;
            if (cnt == '0) begin
              st_nxt  = GAP;
              cnt_nxt = GAP_LD;
            end else begin
              cnt_nxt = cnt - 1'b1;
            end
          end
        end
        GAP: begin
          if (cnt == '0) begin
            st_nxt   = (pend | p) ? ON : IDLE;
            cnt_nxt  = (pend | p) ? HOLD_LD : '0;
            pend_nxt = 1'b0;
          end else begin
            cnt_nxt  = cnt - 1'b1;
            pend_nxt = pend | p;
          end
        end
        default: begin
          st_nxt   = IDLE;
          cnt_nxt  = '0;
          pend_nxt = 1'b0;
        end
      endcase
    end
    // Channel state and LED drive register; reset drops any flash and pending event at once
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        st    <= IDLE;
        cnt   <= '0;
        pend  <= 1'b0;
        led_q <= 1'b0;
      end else begin
        st    <= st_nxt;
        cnt   <= cnt_nxt;
        pend  <= pend_nxt;
        led_q <= st_nxt == ON;
      end
    end
    assign active_nxt[i] = st_nxt != IDLE;
    assign led_out[i]    = led_q;
  end
  // Busy is registered from the same next-state as the channels so it lines up with led_out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= 1'b0;
    else busy <= |active_nxt;
  end
endmodule

// File: tb/tb_led_pulse_stretcher.sv
// tb_led_pulse_stretcher: scoreboard bench for both retrigger modes with short hold/gap
module tb_led_pulse_stretcher;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] pulse_in = '0;
  logic [4:0] led0, led1;
  logic       busy0, busy1;
  int         n_cmp = 0;
  int         n_err = 0;
  typedef struct packed {
    logic [4:0] led0;
    logic       busy0;
    logic [4:0] led1;
    logic       busy1;
  } exp_t;
  exp_t       sb[$];
  logic [4:0] stim[0:25];
  exp_t       e;
  always #5 clk = ~clk;
  led_pulse_stretcher #(.WIDTH(5), .CNT_W(24), .HOLD_CYCLES(4), .GAP_CYCLES(2), .RETRIGGER(0)) dut0 (
    .clk(clk), .reset(reset), .pulse_in(pulse_in), .led_out(led0), .busy(busy0));
  led_pulse_stretcher #(.WIDTH(5), .CNT_W(24), .HOLD_CYCLES(4), .GAP_CYCLES(2), .RETRIGGER(1)) dut1 (
    .clk(clk), .reset(reset), .pulse_in(pulse_in), .led_out(led1), .busy(busy1));
  function automatic logic r(int c, int a, int b);
    return c >= a && c <= b;
  endfunction
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({led0, busy0, led1, busy1} !== 12'b0) begin
      n_err++;
      $display("FAIL reset_state got %b required 0", {led0, busy0, led1, busy1});
    end
    reset = 1'b0;
  endtask
  task automatic test_single();
    for (int c = 0; c < 26; c++) begin
      stim[c] = (c == 10) ? 5'b00001 : 5'b0;
      sb.push_back('{led0: {4'b0, r(c, 11, 14)}, busy0: r(c, 11, 16), led1: {4'b0, r(c, 11, 14)}, busy1: r(c, 11, 16)});
    end
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({led0, busy0, led1, busy1} !== e) begin
        n_err++;
        $display("FAIL single c=%0d got %b required %b", c, {led0, busy0, led1, busy1}, e);
      end
      pulse_in = stim[c];
    end
  endtask
  task automatic test_pending();
    for (int c = 0; c < 26; c++) begin
      stim[c] = (c == 10 || c == 12) ? 5'b00001 : 5'b0;
      sb.push_back('{led0: {4'b0, r(c, 11, 14) | r(c, 17, 20)}, busy0: r(c, 11, 22), led1: {4'b0, r(c, 11, 16)}, busy1: r(c, 11, 18)});
    end
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({led0, busy0, led1, busy1} !== e) begin
        n_err++;
        $display("FAIL pending c=%0d got %b required %b", c, {led0, busy0, led1, busy1}, e);
      end
      pulse_in = stim[c];
    end
  endtask
  task automatic test_retrigger();
    for (int c = 0; c < 26; c++) begin
      stim[c] = (c == 10 || c == 13) ? 5'b00001 : 5'b0;
      sb.push_back('{led0: {4'b0, r(c, 11, 14) | r(c, 17, 20)}, busy0: r(c, 11, 22), led1: {4'b0, r(c, 11, 17)}, busy1: r(c, 11, 19)});
    end
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({led0, busy0, led1, busy1} !== e) begin
        n_err++;
        $display("FAIL retrigger c=%0d got %b required %b", c, {led0, busy0, led1, busy1}, e);
      end
      pulse_in = stim[c];
    end
  endtask
  task automatic test_multi_channel();
    for (int c = 0; c < 26; c++) begin
      stim[c] = (c == 10) ? 5'b01110 : (c == 11 || c == 12) ? 5'b00100 : 5'b0;
      sb.push_back('{led0: {1'b0, r(c, 11, 14), r(c, 11, 14) | r(c, 17, 20), r(c, 11, 14), 1'b0}, busy0: r(c, 11, 22),
                     led1: {1'b0, r(c, 11, 14), r(c, 11, 16), r(c, 11, 14), 1'b0}, busy1: r(c, 11, 18)});
    end
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({led0, busy0, led1, busy1} !== e) begin
        n_err++;
        $display("FAIL multi_channel c=%0d got %b required %b", c, {led0, busy0, led1, busy1}, e);
      end
      pulse_in = stim[c];
    end
  endtask
  task automatic test_gap_edge();
    for (int c = 0; c < 26; c++) begin
      stim[c] = (c == 10 || c == 16) ? 5'b00001 : 5'b0;
      sb.push_back('{led0: {4'b0, r(c, 11, 14) | r(c, 17, 20)}, busy0: r(c, 11, 22), led1: {4'b0, r(c, 11, 14) | r(c, 17, 20)}, busy1: r(c, 11, 22)});
    end
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({led0, busy0, led1, busy1} !== e) begin
        n_err++;
        $display("FAIL gap_edge c=%0d got %b required %b", c, {led0, busy0, led1, busy1}, e);
      end
      pulse_in = stim[c];
    end
  endtask
  task automatic test_on_expiry();
    for (int c = 0; c < 26; c++) begin
      stim[c] = (c == 10 || c == 14) ? 5'b00001 : 5'b0;
      sb.push_back('{led0: {4'b0, r(c, 11, 14) | r(c, 17, 20)}, busy0: r(c, 11, 22), led1: {4'b0, r(c, 11, 18)}, busy1: r(c, 11, 20)});
    end
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({led0, busy0, led1, busy1} !== e) begin
        n_err++;
        $display("FAIL on_expiry c=%0d got %b required %b", c, {led0, busy0, led1, busy1}, e);
      end
      pulse_in = stim[c];
    end
  endtask
  task automatic test_reset_mid_flash();
    for (int c = 0; c < 13; c++) begin
      stim[c] = (c == 10 || c == 11) ? 5'b00001 : 5'b0;
      sb.push_back('{led0: {4'b0, r(c, 11, 14)}, busy0: r(c, 11, 16), led1: {4'b0, r(c, 11, 14)}, busy1: r(c, 11, 16)});
    end
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({led0, busy0, led1, busy1} !== e) begin
        n_err++;
        $display("FAIL reset_pre c=%0d got %b required %b", c, {led0, busy0, led1, busy1}, e);
      end
      pulse_in = (c < 12) ? stim[c] : 5'b0;
    end
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if ({led0, busy0, led1, busy1} !== 12'b0) begin
      n_err++;
      $display("FAIL reset_async got %b required 0", {led0, busy0, led1, busy1});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({led0, busy0, led1, busy1} !== 12'b0) begin
        n_err++;
        $display("FAIL reset_post c=%0d got %b required 0", c, {led0, busy0, led1, busy1});
      end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_pending();
    test_retrigger();
    test_multi_channel();
    test_gap_edge();
    test_on_expiry();
    test_reset_mid_flash();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
